// File: rtl/branch_pc_unit_if.sv
//------------------------------------------------------------------------------
// branch_pc_unit_if
//   Groups the handshake and bus signals of branch_pc_unit.
//   master : decode/branch-resolution and fetch side (drives requests and stall,
//            observes the fetch PC)
//   slave  : branch_pc_unit itself
//   Signals:
//     stall     - freezes sequential PC advance
//     br_valid  - branch-resolution request valid
//     br_ready  - unit can accept a branch request
//     br_taken  - branch condition true, sampled only on handshake
//     br_off    - branch offset (OFF_W bits)
//     br_pc     - next-PC of the branch instruction
//     pc        - current fetch PC
//     pc_valid  - pc is a valid fetch address
//     flush     - high while squashing wrong-path fetches
//     taken_cnt - saturating count of accepted taken branches
//------------------------------------------------------------------------------
interface branch_pc_unit_if #(
    parameter int WIDTH = 16,
    parameter int OFF_W = 5,
    parameter int CNT_W = 8
) ();
    logic             stall;
    logic             br_valid;
    logic             br_ready;
    logic             br_taken;
    logic [OFF_W-1:0] br_off;
    logic [WIDTH-1:0] br_pc;
    logic [WIDTH-1:0] pc;
    logic             pc_valid;
    logic             flush;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output stall, br_valid, br_taken, br_off, br_pc,
        input  br_ready, pc, pc_valid, flush, taken_cnt
    );

    modport slave (
        input  stall, br_valid, br_taken, br_off, br_pc,
        output br_ready, pc, pc_valid, flush, taken_cnt
    );
endinterface

// File: rtl/branch_pc_unit.sv
//------------------------------------------------------------------------------
// branch_pc_unit
//   Registered program counter with branch redirect. Advances the fetch PC by
//   INSTR_BYTES per cycle, redirects to br_pc - INSTR_BYTES + ext(br_off) on an
//   accepted taken branch, then holds pc_valid low for FLUSH_CYCLES cycles
//   while flush is high. Counts accepted taken branches (saturating).
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     bus   - branch_pc_unit_if.slave (request handshake, stall, fetch PC,
//             pc_valid, flush, taken_cnt)
//   All outputs are registers or decodes of the state register only.
//------------------------------------------------------------------------------
module branch_pc_unit #(
    parameter int WIDTH        = 16,
    parameter int OFF_W        = 5,
    parameter int OFF_SIGNED   = 0,
    parameter int INSTR_BYTES  = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int RESET_PC     = 0,
    parameter int CNT_W        = 8
) (
    input logic             clk,
    input logic             rst_n,
    branch_pc_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] PC_RST   = WIDTH'(RESET_PC);
    localparam logic [WIDTH-1:0] PC_STEP  = WIDTH'(INSTR_BYTES);
    localparam logic [3:0]       FLUSH_LD = 4'(FLUSH_CYCLES);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_pc;
    logic [3:0]       r_flush_cnt;
    logic [CNT_W-1:0] r_taken_cnt;

    logic             w_accept;
    logic             w_take;
    logic [WIDTH-1:0] w_off_ext;
    logic [WIDTH-1:0] w_target;

    // Acceptance depends only on state, so br_ready never needs the inputs.
    assign w_accept = (r_state == S_RUN) && bus.br_valid;
    assign w_take   = w_accept && bus.br_taken;

    always_comb begin
        if (OFF_SIGNED != 0) begin
            w_off_ext = WIDTH'($signed(bus.br_off));
        end else begin
            w_off_ext = WIDTH'(bus.br_off);
        end
    end

    // br_pc already points past the branch; back it off to the branch itself.
    assign w_target = bus.br_pc - PC_STEP + w_off_ext;

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_BOOT: begin
                w_next_state = S_RUN;
            end
            S_RUN: begin
                if (w_take && (FLUSH_CYCLES > 0)) begin
                    w_next_state = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // <= 1 so a stray zero count can never wedge the unit.
                if (r_flush_cnt <= 4'd1) begin
                    w_next_state = S_RUN;
                end
            end
            default: begin
                w_next_state = S_BOOT;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Output decode (state only)
    //--------------------------------------------------------------------------
    always_comb begin
        bus.br_ready = 1'b0;
        bus.pc_valid = 1'b0;
        bus.flush    = 1'b0;
        case (r_state)
            S_RUN: begin
                bus.br_ready = 1'b1;
                bus.pc_valid = 1'b1;
            end
            S_FLUSH: begin
                bus.flush = 1'b1;
            end
            default: begin
                bus.br_ready = 1'b0;
                bus.pc_valid = 1'b0;
                bus.flush    = 1'b0;
            end
        endcase
    end

    assign bus.pc        = r_pc;
    assign bus.taken_cnt = r_taken_cnt;

    //--------------------------------------------------------------------------
    // PC, flush counter and taken-branch counter
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= PC_RST;
            r_flush_cnt <= '0;
            r_taken_cnt <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_take) begin
                        // Redirect wins over stall.
                        r_pc <= w_target;
                        if (r_taken_cnt != '1) begin
                            r_taken_cnt <= r_taken_cnt + 1'b1;
                        end
                        if (FLUSH_CYCLES > 0) begin
                            r_flush_cnt <= FLUSH_LD;
                        end
                    end else if (!bus.stall) begin
                        r_pc <= r_pc + PC_STEP;
                    end
                end
                S_FLUSH: begin
                    // PC parks on the target; countdown ignores stall.
                    if (r_flush_cnt != '0) begin
                        r_flush_cnt <= r_flush_cnt - 4'd1;
                    end
                end
                default: begin
                    r_pc <= r_pc;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_pc_unit.sv
module tb_branch_pc_unit;

    logic clk;
    logic rst_n;

    int unsigned n_total;
    int unsigned n_bad;

    branch_pc_unit_if #(.WIDTH(16), .OFF_W(5), .CNT_W(8)) bus_u ();
    branch_pc_unit_if #(.WIDTH(16), .OFF_W(5), .CNT_W(8)) bus_s ();

    branch_pc_unit #(
        .WIDTH(16), .OFF_W(5), .OFF_SIGNED(0), .INSTR_BYTES(2),
        .FLUSH_CYCLES(2), .RESET_PC(0), .CNT_W(8)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_u)
    );

    branch_pc_unit #(
        .WIDTH(16), .OFF_W(5), .OFF_SIGNED(1), .INSTR_BYTES(2),
        .FLUSH_CYCLES(2), .RESET_PC(0), .CNT_W(8)
    ) u_dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_u(input string tag, input logic [15:0] pc, input logic pv,
                           input logic fl, input logic rdy, input logic [7:0] cnt);
        check({tag, ".pc"},    32'(bus_u.pc),        32'(pc));
        check({tag, ".valid"}, 32'(bus_u.pc_valid),  32'(pv));
        check({tag, ".flush"}, 32'(bus_u.flush),     32'(fl));
        check({tag, ".ready"}, 32'(bus_u.br_ready),  32'(rdy));
        check({tag, ".cnt"},   32'(bus_u.taken_cnt), 32'(cnt));
    endtask

    initial begin
        logic [15:0] seq [4];
        seq = '{16'h0000, 16'h0002, 16'h0004, 16'h0006};
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        bus_u.stall = 1'b0; bus_u.br_valid = 1'b0; bus_u.br_taken = 1'b0;
        bus_u.br_off = '0;  bus_u.br_pc = '0;
        bus_s.stall = 1'b0; bus_s.br_valid = 1'b0; bus_s.br_taken = 1'b0;
        bus_s.br_off = '0;  bus_s.br_pc = '0;

        // 1: reset, boot, sequential advance
        tick(); tick();
        check_u("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        #1;
        check_u("boot", 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_u($sformatf("seq%0d", i), seq[i], 1'b1, 1'b0, 1'b1, 8'h00);
        end

        // 2: taken branch, flush sequence
        bus_u.br_valid = 1'b1; bus_u.br_taken = 1'b1;
        bus_u.br_pc = 16'h0010; bus_u.br_off = 5'd5;
        tick();
        bus_u.br_valid = 1'b0;
        check_u("tk.f1", 16'h0013, 1'b0, 1'b1, 1'b0, 8'h01);
        tick();
        check_u("tk.f2", 16'h0013, 1'b0, 1'b1, 1'b0, 8'h01);
        tick();
        check_u("tk.run", 16'h0013, 1'b1, 1'b0, 1'b1, 8'h01);
        tick();
        check_u("tk.adv", 16'h0015, 1'b1, 1'b0, 1'b1, 8'h01);

        // 4: steer to 0x0008, then not-taken request and stall
        bus_u.br_valid = 1'b1; bus_u.br_taken = 1'b1;
        bus_u.br_pc = 16'h000A; bus_u.br_off = 5'd0;
        tick();
        bus_u.br_valid = 1'b0;
        tick(); tick();
        check_u("to8", 16'h0008, 1'b1, 1'b0, 1'b1, 8'h02);
        bus_u.br_valid = 1'b1; bus_u.br_taken = 1'b0;
        bus_u.br_pc = 16'h0040; bus_u.br_off = 5'd7;
        tick();
        bus_u.br_valid = 1'b0;
        check_u("nt", 16'h000A, 1'b1, 1'b0, 1'b1, 8'h02);
        bus_u.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_u($sformatf("stall%0d", i), 16'h000A, 1'b1, 1'b0, 1'b1, 8'h02);
        end

        // 5: taken branch under stall; request held during flush is ignored
        bus_u.br_valid = 1'b1; bus_u.br_taken = 1'b1;
        bus_u.br_pc = 16'h0020; bus_u.br_off = 5'd0;
        tick();
        check_u("stk.f1", 16'h001E, 1'b0, 1'b1, 1'b0, 8'h03);
        bus_u.br_pc = 16'h0050; bus_u.br_off = 5'd3;
        tick();
        check_u("stk.f2", 16'h001E, 1'b0, 1'b1, 1'b0, 8'h03);
        tick();
        bus_u.br_valid = 1'b0;
        check_u("stk.run", 16'h001E, 1'b1, 1'b0, 1'b1, 8'h03);
        tick();
        check_u("stk.hold", 16'h001E, 1'b1, 1'b0, 1'b1, 8'h03);
        bus_u.stall = 1'b0;
        tick();
        check_u("stk.adv", 16'h0020, 1'b1, 1'b0, 1'b1, 8'h03);

        // 3: sign-extended offsets on the second instance
        bus_s.br_valid = 1'b1; bus_s.br_taken = 1'b1;
        bus_s.br_pc = 16'h0010; bus_s.br_off = 5'b11100;
        tick();
        bus_s.br_valid = 1'b0;
        check("sgn.pc",    32'(bus_s.pc),    32'h000A);
        check("sgn.flush", 32'(bus_s.flush), 32'h1);
        tick(); tick();
        check("sgn.valid", 32'(bus_s.pc_valid), 32'h1);
        bus_s.br_valid = 1'b1;
        bus_s.br_pc = 16'h0000; bus_s.br_off = 5'b11100;
        tick();
        bus_s.br_valid = 1'b0;
        check("sgn.wrap", 32'(bus_s.pc), 32'h0000_FFFA);
        check("sgn.cnt",  32'(bus_s.taken_cnt), 32'h2);

        // 6: asynchronous reset during the first flush cycle
        bus_u.br_valid = 1'b1; bus_u.br_taken = 1'b1;
        bus_u.br_pc = 16'h0030; bus_u.br_off = 5'd1;
        tick();
        bus_u.br_valid = 1'b0;
        check_u("rf.f1", 16'h002F, 1'b0, 1'b1, 1'b0, 8'h04);
        rst_n = 1'b0;
        #1;
        check_u("rf.rst", 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        rst_n = 1'b1;
        #1;
        check_u("rf.boot", 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        check_u("rf.run", 16'h0000, 1'b1, 1'b0, 1'b1, 8'h00);
        tick();
        check_u("rf.adv", 16'h0002, 1'b1, 1'b0, 1'b1, 8'h00);

        // Saturation: one acceptance every 3 edges while the request is held
        bus_u.br_valid = 1'b1; bus_u.br_taken = 1'b1;
        bus_u.br_pc = 16'h0100; bus_u.br_off = 5'd0;
        for (int i = 0; i < 30; i++) tick();
        check("sat.10", 32'(bus_u.taken_cnt), 32'd10);
        for (int i = 0; i < 800; i++) tick();
        check("sat.ff", 32'(bus_u.taken_cnt), 32'hFF);
        bus_u.br_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
